// File: rtl/agv_shift_ctrl.sv
// rtl/agv_shift_ctrl.sv - serial shift/latch driver for an AGV shift-register chain
// Shifts one DATA_W word out on AGV_DATA/AGV_CLK, then pulses AGV_LTCH for LTCH_CYC cycles.
module agv_shift_ctrl #(
  parameter int DATA_W    = 16,
  parameter int DIV       = 4,
  parameter int LTCH_CYC  = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              AGV_DATA,
  output logic              AGV_CLK,
  output logic              AGV_LTCH
);

  localparam int HW = $clog2(DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int LW = $clog2(LTCH_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              data_q, data_d;
  logic              clk_q, clk_d;
  logic              ltch_q, ltch_d;
  logic [DATA_W-1:0] sr_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  assign sr_next = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q <= IDLE;
      sr_q    <= '0;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 1'b0;
      clk_q   <= 1'b0;
      ltch_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      clk_q   <= clk_d;
      ltch_q  <= ltch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    clk_d   = clk_q;
    ltch_d  = ltch_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        clk_d  = 1'b0;
        data_d = 1'b0;
        ltch_d = 1'b0;
        if (start) begin
          sr_d    = din;
          busy_d  = 1'b1;
          data_d  = first_bit(din);
          hcnt_d  = '0;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (hcnt_q == HW'(DIV - 1)) begin
          hcnt_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            // Falling AGV_CLK edge: advance to the next bit or finish the word.
            clk_d  = 1'b0;
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BW'(DATA_W - 1)) begin
              data_d  = 1'b0;
              ltch_d  = 1'b1;
              lcnt_d  = '0;
              state_d = LATCH;
            end else begin
              sr_d   = sr_next;
              data_d = first_bit(sr_next);
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (lcnt_q == LW'(LTCH_CYC - 1)) begin
          ltch_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign AGV_DATA = data_q;
  assign AGV_CLK  = clk_q;
  assign AGV_LTCH = ltch_q;

endmodule
